// File: rtl/fpu_add_issue.sv
// rtl/fpu_add_issue.sv - request FIFO and operand sequencer for the single-precision FP adder
module fpu_add_issue #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic [31:0] add_a,
    output logic        add_a_stb,
    output logic [31:0] add_b,
    output logic        add_b_stb,
    input  logic [31:0] add_z,
    input  logic        add_z_stb,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_nv,
    input  logic        wb_ack,
    output logic        busy,
    output logic        timeout_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 70;

    typedef enum logic [2:0] {S_IDLE, S_SEND_A, S_SEND_B, S_WAIT, S_WB} state_t;

    state_t             state, state_nxt;
    logic [EW-1:0]      mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [PW:0]        count;
    logic [CNT_W-1:0]   wd_cnt;
    logic [31:0]        b_lat;
    logic               push, pop, fifo_empty, timeout_hit;
    logic [EW-1:0]      head;
    logic               op_h, nv_h;
    logic [31:0]        a_h, b_h, b_eff;
    logic [4:0]         rd_h;

    function automatic logic is_snan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && !x[22] && (x[21:0] != 22'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    assign fifo_empty  = (count == '0);
    assign req_ready   = (count != (PW+1)'(DEPTH));
    assign push        = req_valid && req_ready;
    assign pop         = !fifo_empty && ((state == S_IDLE) || (state == S_WB && wb_ack));
    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT - 1));

    assign head  = mem[rd_ptr];
    assign op_h  = head[69];
    assign a_h   = head[68:37];
    assign b_h   = head[36:5];
    assign rd_h  = head[4:0];
    // Subtract is folded into the operand: flipping the sign also flips NaNs, which is harmless.
    assign b_eff = {b_h[31] ^ op_h, b_h[30:0]};
    assign nv_h  = is_snan(a_h) || is_snan(b_eff) ||
                   (is_inf(a_h) && is_inf(b_eff) && (a_h[31] != b_eff[31]));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_op, req_a, req_b, req_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pop) state_nxt = S_SEND_A;
            S_SEND_A: state_nxt = S_SEND_B;
            S_SEND_B: state_nxt = S_WAIT;
            S_WAIT:   if (add_z_stb || timeout_hit) state_nxt = S_WB;
            S_WB:     if (wb_ack) state_nxt = fifo_empty ? S_IDLE : S_SEND_A;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        add_a_stb = (state == S_SEND_A);
        add_b_stb = (state == S_SEND_B);
        wb_valid  = (state == S_WB);
        busy      = !fifo_empty || (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            add_a       <= '0;
            add_b       <= '0;
            b_lat       <= '0;
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_nv       <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) begin
                add_a <= a_h;
                b_lat <= b_eff;
                wb_rd <= rd_h;
                wb_nv <= nv_h;
            end
            if (state == S_SEND_A) add_b <= b_lat;
            if (state == S_SEND_B) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT) begin
                wd_cnt <= wd_cnt + CNT_W'(1);
            end
            // A result strobe arriving on the last watchdog cycle takes priority over the abort.
            if (state == S_WAIT) begin
                if (add_z_stb) begin
                    wb_data <= add_z;
                end else if (timeout_hit) begin
                    wb_data     <= 32'h7FC0_0000;
                    wb_nv       <= 1'b1;
                    timeout_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fpu_add_issue.sv
// tb/tb_fpu_add_issue.sv - directed bench for fpu_add_issue with a behavioural adder
module tb_fpu_add_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_op = 1'b0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [4:0]  req_rd = '0;
    logic        req_ready;
    logic [31:0] add_a, add_b;
    logic        add_a_stb, add_b_stb;
    logic [31:0] add_z = '0;
    logic        add_z_stb = 1'b0;
    logic        wb_valid, wb_nv, wb_ack = 1'b0, busy, timeout_err;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpu_add_issue #(.DEPTH(2), .TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .add_a(add_a), .add_a_stb(add_a_stb), .add_b(add_b), .add_b_stb(add_b_stb),
        .add_z(add_z), .add_z_stb(add_z_stb),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_nv(wb_nv),
        .wb_ack(wb_ack), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Adder model: returns the next queued result lat_cfg cycles after add_b_stb.
    logic [31:0] res_q[$];
    bit          hang = 0, manual = 0, counting = 0, seq_ok = 0, prev_a = 0, prev_wbv = 0;
    int          lat_cfg = 12, lat_cnt = 0, cyc = 0, b_cyc = 0, lat_meas = 0;
    logic [31:0] cap_a = '0, cap_b = '0;

    always @(negedge clk) begin
        cyc++;
        if (!manual) begin
            add_z_stb = 1'b0;
            if (!rst) begin
                counting = 0;
            end else begin
                if (counting) begin
                    lat_cnt--;
                    if (lat_cnt == 0) begin
                        counting  = 0;
                        add_z_stb = 1'b1;
                        add_z     = (res_q.size() > 0) ? res_q.pop_front() : 32'h0;
                    end
                end
                if (add_b_stb && !hang) begin
                    counting = 1;
                    lat_cnt  = lat_cfg;
                end
            end
        end
        if (add_a_stb) cap_a = add_a;
        if (add_b_stb) begin
            cap_b  = add_b;
            seq_ok = prev_a;
            b_cyc  = cyc;
        end
        prev_a = add_a_stb;
        if (wb_valid && !prev_wbv) lat_meas = cyc - b_cyc;
        prev_wbv = wb_valid;
    end

    task automatic push(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        check("req_ready_at_push", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_wb(input int max_cyc);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (wb_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        #1;
        if (!ok) check("wb_valid_wait", 0, 1);
    endtask

    task automatic expect_wb(input string tag, input logic [31:0] data, input logic [4:0] rd, input logic nv);
        wait_wb(300);
        check({tag, "_data"}, wb_data, data);
        check({tag, "_rd"}, wb_rd, rd);
        check({tag, "_nv"}, wb_nv, nv);
        @(negedge clk);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        check({tag, "_valid_drop"}, wb_valid, 0);
    endtask

    typedef struct {logic op; logic [31:0] a; logic [31:0] b; logic nv;} nv_vec_t;
    nv_vec_t nv_tab[5] = '{
        '{1'b0, 32'h7F80_0000, 32'hFF80_0000, 1'b1},
        '{1'b0, 32'h7F80_0001, 32'h3F80_0000, 1'b1},
        '{1'b0, 32'h7FC0_0000, 32'h3F80_0000, 1'b0},
        '{1'b1, 32'h7F80_0000, 32'h7F80_0000, 1'b1},
        '{1'b0, 32'h7F80_0000, 32'h7F80_0000, 1'b0}
    };

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_add_a_stb", add_a_stb, 0);
        check("rst_add_b_stb", add_b_stb, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b1;
        @(negedge clk);

        res_q.push_back(32'h4040_0000);
        push(1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        expect_wb("fadd", 32'h4040_0000, 5'd5, 1'b0);
        check("fadd_add_a", cap_a, 32'h3F80_0000);
        check("fadd_add_b", cap_b, 32'h4000_0000);
        check("fadd_stb_consecutive", seq_ok, 1);
        check("fadd_latency", lat_meas, 13);

        res_q.push_back(32'h4000_0000);
        push(1'b1, 32'h4040_0000, 32'h3F80_0000, 5'd7);
        expect_wb("fsub", 32'h4000_0000, 5'd7, 1'b0);
        check("fsub_add_b", cap_b, 32'hBF80_0000);

        for (int i = 0; i < 5; i++) begin
            res_q.push_back(32'h7FC0_0000);
            push(nv_tab[i].op, nv_tab[i].a, nv_tab[i].b, 5'(i + 10));
            expect_wb($sformatf("nv%0d", i), 32'h7FC0_0000, 5'(i + 10), nv_tab[i].nv);
        end

        res_q.push_back(32'h1111_1111);
        res_q.push_back(32'h2222_2222);
        res_q.push_back(32'h3333_3333);
        push(1'b0, 32'h3F80_0000, 32'h3F80_0000, 5'd1);
        push(1'b0, 32'h4000_0000, 32'h4000_0000, 5'd2);
        push(1'b0, 32'h4040_0000, 32'h4040_0000, 5'd3);
        check("b2b_full_ready", req_ready, 0);
        check("b2b_busy", busy, 1);
        wait_wb(300);
        repeat (5) @(negedge clk);
        check("b2b_hold_valid", wb_valid, 1);
        check("b2b_hold_data", wb_data, 32'h1111_1111);
        check("b2b_hold_ready", req_ready, 0);
        expect_wb("b2b0", 32'h1111_1111, 5'd1, 1'b0);
        expect_wb("b2b1", 32'h2222_2222, 5'd2, 1'b0);
        expect_wb("b2b2", 32'h3333_3333, 5'd3, 1'b0);
        repeat (2) @(negedge clk);
        check("b2b_idle_busy", busy, 0);

        lat_cfg = 64;
        res_q.push_back(32'h4120_0000);
        push(1'b0, 32'h40A0_0000, 32'h40A0_0000, 5'd20);
        expect_wb("edge", 32'h4120_0000, 5'd20, 1'b0);
        check("edge_latency", lat_meas, 65);
        check("edge_timeout_err", timeout_err, 0);

        hang = 1;
        push(1'b0, 32'h3F80_0000, 32'h3F80_0000, 5'd9);
        expect_wb("hang", 32'h7FC0_0000, 5'd9, 1'b1);
        check("hang_latency", lat_meas, 65);
        check("hang_timeout_err", timeout_err, 1);
        hang = 0;
        lat_cfg = 12;
        res_q.push_back(32'h4080_0000);
        push(1'b0, 32'h4000_0000, 32'h4000_0000, 5'd4);
        expect_wb("after_hang", 32'h4080_0000, 5'd4, 1'b0);
        check("sticky_timeout_err", timeout_err, 1);

        hang = 1;
        push(1'b0, 32'h3F80_0000, 32'h3F80_0000, 5'd6);
        push(1'b0, 32'h4000_0000, 32'h3F80_0000, 5'd8);
        for (int i = 0; i < 20 && !add_b_stb; i++) @(negedge clk);
        check("rst_mid_saw_add_b", add_b_stb, 1);
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_wb_valid", wb_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_req_ready", req_ready, 1);
        check("rst_mid_timeout_err", timeout_err, 0);
        rst = 1'b1;
        manual = 1;
        add_z = 32'hDEAD_BEEF;
        add_z_stb = 1'b1;
        @(negedge clk);
        add_z_stb = 1'b0;
        repeat (3) @(negedge clk);
        check("late_stb_wb_valid", wb_valid, 0);
        check("late_stb_busy", busy, 0);
        check("late_stb_wb_data", wb_data, 0);
        check("late_stb_add_a_stb", add_a_stb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
